// File: rtl/tom_motion_ctl.sv
// Per-frame walk/jump/gravity/landing controller for the Tom sprite against six platforms and the floor.
// Latency: position/state update on the frame_tick cycle, visible the cycle after; no backpressure.
// Optional build macro TOM_DOUBLE_JUMP_EN enables one mid-air jump per airborne phase.
module tom_motion_ctl #(
    parameter int X_INIT    = 100,
    parameter int Y_INIT    = 718,
    parameter int FLOOR_Y   = 768,
    parameter int SCREEN_W  = 1024,
    parameter int WALK_STEP = 4,
    parameter int JUMP_V0   = 20,
    parameter int VMAX      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        on_ground,
    output logic [1:0]  state,
    output logic        facing_left
);

    localparam int TOM_WIDTH  = 32;
    localparam int TOM_HEIGHT = 50;
    localparam int NPLAT      = 6;
    localparam int P_XS [NPLAT] = '{180, 780,   0, 500, 600, 125};
    localparam int P_XE [NPLAT] = '{650, 920, 250, 600, 975, 450};
    localparam int P_YC [NPLAT] = '{600, 600, 460, 460, 320, 220};

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic [5:0]  r_vy;
    logic        r_facing_left;
    logic        r_jump_req;
    logic        r_jump_prev;

    state_t      w_state_nxt;
    logic [11:0] w_x_nxt;
    logic [11:0] w_y_nxt;
    logic [5:0]  w_vy_nxt;
    logic        w_face_nxt;
    logic        w_jump_rise;
    logic        w_jump_eff;
    logic        w_air_jump;
    logic [12:0] w_feet;
    logic [12:0] w_feet_new;
    logic [5:0]  w_vy_inc;
    logic [5:0]  w_vy_dec;
    logic [11:0] w_rise_y;
    logic        w_supported;
    logic        w_hit;
    logic [12:0] w_land;

    function automatic logic f_overlap(input logic [11:0] x, input int xs, input int xe);
        return (({1'b0, x} + 13'(TOM_WIDTH)) > 13'(xs)) && ({1'b0, x} < 13'(xe));
    endfunction

    // A press landing on the tick cycle itself is honoured by that tick.
    assign w_jump_rise = btn_jump & ~r_jump_prev;
    assign w_jump_eff  = r_jump_req | w_jump_rise;

`ifdef TOM_DOUBLE_JUMP_EN
    logic r_air_jump_used;
    assign w_air_jump = w_jump_eff & ~r_air_jump_used;
`else
    assign w_air_jump = 1'b0;
`endif

    always_comb begin
        w_x_nxt    = r_xpos;
        w_face_nxt = r_facing_left;
        if (btn_left && !btn_right) begin
            w_x_nxt    = (r_xpos < 12'(WALK_STEP)) ? 12'd0 : r_xpos - 12'(WALK_STEP);
            w_face_nxt = 1'b1;
        end else if (btn_right && !btn_left) begin
            w_x_nxt    = (r_xpos >= 12'(SCREEN_W - TOM_WIDTH - WALK_STEP)) ?
                         12'(SCREEN_W - TOM_WIDTH) : r_xpos + 12'(WALK_STEP);
            w_face_nxt = 1'b0;
        end
    end

    always_comb begin
        w_feet      = 13'(r_ypos) + 13'(TOM_HEIGHT);
        w_vy_inc    = (r_vy >= 6'(VMAX)) ? 6'(VMAX) : r_vy + 6'd1;
        w_feet_new  = w_feet + 13'(w_vy_inc);
        w_vy_dec    = (r_vy == 6'd0) ? 6'd0 : r_vy - 6'd1;
        w_rise_y    = (r_ypos < 12'(r_vy)) ? 12'd0 : r_ypos - 12'(r_vy);
        w_supported = (w_feet == 13'(FLOOR_Y));
        w_hit       = 1'b0;
        w_land      = 13'h1FFF;
        // Several platforms may be crossed in one tick; the highest one wins.
        for (int i = 0; i < NPLAT; i++) begin
            if (f_overlap(w_x_nxt, P_XS[i], P_XE[i])) begin
                if (w_feet == 13'(P_YC[i]))
                    w_supported = 1'b1;
                if (w_feet <= 13'(P_YC[i]) && w_feet_new >= 13'(P_YC[i]) &&
                    13'(P_YC[i]) < w_land) begin
                    w_hit  = 1'b1;
                    w_land = 13'(P_YC[i]);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_ypos;
        w_vy_nxt    = r_vy;
        unique case (r_state)
            ST_GROUND: begin
                if (w_jump_eff) begin
                    w_state_nxt = ST_RISE;
                    w_vy_nxt    = 6'(JUMP_V0);
                end else if (!w_supported) begin
                    w_state_nxt = ST_FALL;
                    w_vy_nxt    = 6'd0;
                end
            end
            ST_RISE: begin
                if (w_air_jump) begin
                    w_vy_nxt = 6'(JUMP_V0);
                end else begin
                    w_y_nxt  = w_rise_y;
                    w_vy_nxt = w_vy_dec;
                    if (w_vy_dec == 6'd0)
                        w_state_nxt = ST_FALL;
                end
            end
            ST_FALL: begin
                if (w_air_jump) begin
                    w_state_nxt = ST_RISE;
                    w_vy_nxt    = 6'(JUMP_V0);
                end else if (w_hit) begin
                    w_state_nxt = ST_GROUND;
                    w_y_nxt     = 12'(w_land - 13'(TOM_HEIGHT));
                    w_vy_nxt    = 6'd0;
                end else if (w_feet_new >= 13'(FLOOR_Y)) begin
                    w_state_nxt = ST_GROUND;
                    w_y_nxt     = 12'(FLOOR_Y - TOM_HEIGHT);
                    w_vy_nxt    = 6'd0;
                end else begin
                    w_y_nxt  = r_ypos + 12'(w_vy_inc);
                    w_vy_nxt = w_vy_inc;
                end
            end
            default: begin
                w_state_nxt = ST_GROUND;
                w_vy_nxt    = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_GROUND;
            r_xpos        <= 12'(X_INIT);
            r_ypos        <= 12'(Y_INIT);
            r_vy          <= 6'd0;
            r_facing_left <= 1'b0;
            r_jump_req    <= 1'b0;
            r_jump_prev   <= 1'b0;
        end else begin
            r_jump_prev <= btn_jump;
            if (frame_tick) begin
                r_state       <= w_state_nxt;
                r_xpos        <= w_x_nxt;
                r_ypos        <= w_y_nxt;
                r_vy          <= w_vy_nxt;
                r_facing_left <= w_face_nxt;
                r_jump_req    <= 1'b0;
            end else if (w_jump_rise) begin
                r_jump_req <= 1'b1;
            end
        end
    end

`ifdef TOM_DOUBLE_JUMP_EN
    always_ff @(posedge clk) begin
        if (rst)
            r_air_jump_used <= 1'b0;
        else if (frame_tick) begin
            if (r_state != ST_GROUND && w_air_jump)
                r_air_jump_used <= 1'b1;
            else if (w_state_nxt == ST_GROUND)
                r_air_jump_used <= 1'b0;
        end
    end
`endif

    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign state       = r_state;
    assign on_ground   = (r_state == ST_GROUND);
    assign facing_left = r_facing_left;

endmodule

// File: tb/tb_tom_motion_ctl.sv
// Directed bench for tom_motion_ctl: walking, saturation, jump arcs, platform landing, walk-off and reset.
module tb_tom_motion_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        on_ground;
    logic [1:0]  state;
    logic        facing_left;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tom_motion_ctl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .xpos(xpos), .ypos(ypos), .on_ground(on_ground),
        .state(state), .facing_left(facing_left)
    );

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic pulse_jump();
        @(negedge clk) btn_jump = 1'b1;
        @(negedge clk) btn_jump = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (xpos !== 12'd100) begin n_err++; $display("FAIL reset_x: got %0d want 100", xpos); end
        n_cmp++; if (ypos !== 12'd718) begin n_err++; $display("FAIL reset_y: got %0d want 718", ypos); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (on_ground !== 1'b1) begin n_err++; $display("FAIL reset_on_ground: got %0b want 1", on_ground); end
        n_cmp++; if (facing_left !== 1'b0) begin n_err++; $display("FAIL reset_facing: got %0b want 0", facing_left); end
    endtask

    task automatic test_walk();
        btn_right = 1'b1;
        repeat (10) tick();
        n_cmp++; if (xpos !== 12'd140) begin n_err++; $display("FAIL walk_right_x: got %0d want 140", xpos); end
        n_cmp++; if (ypos !== 12'd718) begin n_err++; $display("FAIL walk_right_y: got %0d want 718", ypos); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL walk_right_state: got %0d want 0", state); end
        n_cmp++; if (facing_left !== 1'b0) begin n_err++; $display("FAIL walk_right_facing: got %0b want 0", facing_left); end
        btn_left = 1'b1;
        repeat (3) tick();
        n_cmp++; if (xpos !== 12'd140) begin n_err++; $display("FAIL walk_both_x: got %0d want 140", xpos); end
        btn_right = 1'b0;
        tick();
        n_cmp++; if (xpos !== 12'd136) begin n_err++; $display("FAIL walk_left_x: got %0d want 136", xpos); end
        n_cmp++; if (facing_left !== 1'b1) begin n_err++; $display("FAIL walk_left_facing: got %0b want 1", facing_left); end
        btn_left = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (xpos !== 12'd136) begin n_err++; $display("FAIL no_tick_hold_x: got %0d want 136", xpos); end
    endtask

    task automatic test_saturation();
        btn_left = 1'b1;
        repeat (33) tick();
        n_cmp++; if (xpos !== 12'd4) begin n_err++; $display("FAIL sat_left_pre_x: got %0d want 4", xpos); end
        repeat (2) tick();
        n_cmp++; if (xpos !== 12'd0) begin n_err++; $display("FAIL sat_left_x: got %0d want 0", xpos); end
        btn_left = 1'b0;
        btn_right = 1'b1;
        repeat (260) tick();
        n_cmp++; if (xpos !== 12'd992) begin n_err++; $display("FAIL sat_right_x: got %0d want 992", xpos); end
        n_cmp++; if (facing_left !== 1'b0) begin n_err++; $display("FAIL sat_right_facing: got %0b want 0", facing_left); end
        btn_right = 1'b0;
    endtask

    task automatic test_jump_land_p1();
        do_reset();
        btn_right = 1'b1;
        repeat (50) tick();
        btn_right = 1'b0;
        n_cmp++; if (xpos !== 12'd300) begin n_err++; $display("FAIL jump_start_x: got %0d want 300", xpos); end
        pulse_jump();
        tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL jump_enter_rise: got %0d want 1", state); end
        n_cmp++; if (ypos !== 12'd718) begin n_err++; $display("FAIL jump_enter_y: got %0d want 718", ypos); end
        tick();
        n_cmp++; if (ypos !== 12'd698) begin n_err++; $display("FAIL rise1_y: got %0d want 698", ypos); end
        repeat (18) tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL rise19_state: got %0d want 1", state); end
        tick();
        n_cmp++; if (ypos !== 12'd508) begin n_err++; $display("FAIL apex_y: got %0d want 508", ypos); end
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL apex_state: got %0d want 2", state); end
        repeat (8) tick();
        n_cmp++; if (ypos !== 12'd544) begin n_err++; $display("FAIL fall8_y: got %0d want 544", ypos); end
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL fall8_state: got %0d want 2", state); end
        tick();
        n_cmp++; if (ypos !== 12'd550) begin n_err++; $display("FAIL land_p1_y: got %0d want 550", ypos); end
        n_cmp++; if (on_ground !== 1'b1) begin n_err++; $display("FAIL land_p1_ground: got %0b want 1", on_ground); end
    endtask

    task automatic test_walk_off();
        btn_right = 1'b1;
        repeat (85) tick();
        n_cmp++; if (xpos !== 12'd640) begin n_err++; $display("FAIL p1_walk_x: got %0d want 640", xpos); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL p1_walk_state: got %0d want 0", state); end
        repeat (2) tick();
        n_cmp++; if (xpos !== 12'd648) begin n_err++; $display("FAIL p1_edge_x: got %0d want 648", xpos); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL p1_edge_state: got %0d want 0", state); end
        tick();
        btn_right = 1'b0;
        n_cmp++; if (xpos !== 12'd652) begin n_err++; $display("FAIL walkoff_x: got %0d want 652", xpos); end
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL walkoff_state: got %0d want 2", state); end
        n_cmp++; if (ypos !== 12'd550) begin n_err++; $display("FAIL walkoff_y: got %0d want 550", ypos); end
        repeat (17) tick();
        n_cmp++; if (ypos !== 12'd703) begin n_err++; $display("FAIL drop17_y: got %0d want 703", ypos); end
        tick();
        n_cmp++; if (ypos !== 12'd718) begin n_err++; $display("FAIL floor_land_y: got %0d want 718", ypos); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL floor_land_state: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        pulse_jump();
        tick();
        repeat (5) tick();
        n_cmp++; if (ypos !== 12'd628) begin n_err++; $display("FAIL rise5_y: got %0d want 628", ypos); end
        @(negedge clk) begin rst = 1'b1; frame_tick = 1'b1; end
        @(negedge clk) begin rst = 1'b0; frame_tick = 1'b0; end
        n_cmp++; if (ypos !== 12'd718) begin n_err++; $display("FAIL rst_mid_y: got %0d want 718", ypos); end
        n_cmp++; if (xpos !== 12'd100) begin n_err++; $display("FAIL rst_mid_x: got %0d want 100", xpos); end
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", state); end
        pulse_jump();
        do_reset();
        tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_discard_jump: got %0d want 0", state); end
        n_cmp++; if (ypos !== 12'd718) begin n_err++; $display("FAIL rst_discard_y: got %0d want 718", ypos); end
    endtask

    task automatic test_air_jump();
        do_reset();
        pulse_jump();
        tick();
        repeat (20) tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL aj_apex_state: got %0d want 2", state); end
        pulse_jump();
        tick();
`ifdef TOM_DOUBLE_JUMP_EN
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL aj_second_state: got %0d want 1", state); end
        n_cmp++; if (ypos !== 12'd508) begin n_err++; $display("FAIL aj_second_y: got %0d want 508", ypos); end
        tick();
        n_cmp++; if (ypos !== 12'd488) begin n_err++; $display("FAIL aj_second_rise_y: got %0d want 488", ypos); end
        pulse_jump();
        tick();
        n_cmp++; if (ypos !== 12'd469) begin n_err++; $display("FAIL aj_third_ignored_y: got %0d want 469", ypos); end
`else
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL aj_ignored_state: got %0d want 2", state); end
        n_cmp++; if (ypos !== 12'd509) begin n_err++; $display("FAIL aj_ignored_y: got %0d want 509", ypos); end
        tick();
        n_cmp++; if (ypos !== 12'd511) begin n_err++; $display("FAIL aj_fall2_y: got %0d want 511", ypos); end
        pulse_jump();
        tick();
        n_cmp++; if (ypos !== 12'd514) begin n_err++; $display("FAIL aj_fall3_y: got %0d want 514", ypos); end
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_walk();
        test_saturation();
        test_jump_land_p1();
        test_walk_off();
        test_reset_mid_jump();
        test_air_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
